alu_exec_q: RTL
===============

# alu_exec_q

Parametrised RV32I integer execute unit: combinational ALU feeding a DEPTH-entry in-order output queue with a `wb_*` writeback handshake. Sits between the ALU reservation-station issue port and the CDB/writeback arbiter. Adds three capabilities: multi-entry buffering, epoch-based squash of stale results, and full-queue flush.

## Interface
Parameters:
- `DEPTH`, 2: output-queue entries; power of two, ≥2.
- `FULL_SKID`, 1: 1 lets a full queue accept a request in a cycle where the head dequeues; 0 requires count < DEPTH.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: issue request valid.
- `req_ready` out 1: block accepts the request this cycle.
- `req_uop` in `rs_uop_t`: issued uop; carries `bundle`, `rob_idx`, `prd_new`, `epoch`.
- `rs1_val` in 32: source-1 operand.
- `rs2_val` in 32: source-2 operand.
- `cur_epoch` in 2: current front-end epoch.
- `flush` in 1: discard every queued entry and any request this cycle.
- `wb_valid` out 1: head result offered to writeback.
- `wb_ready` in 1: writeback consumer accepts the head.
- `wb_pc` out 32, `wb_uses_rd` out 1, `wb_rob_idx` out ROB_W, `wb_prd_new` out PHYS_W, `wb_epoch` out 2, `wb_data` out 32: head payload.
- `occupancy` out $clog2(DEPTH+1): valid-entry count.

## Operation
- Operand select: src1 is `rs1_val` for SRC_RS1, else 0. src2 is `rs2_val` for SRC_RS2, `imm` for SRC_IMM, else 0. shamt = `imm[4:0]`.
- Ops:
  - ADD/ADDI/AUIPC: a+b.
  - SUB: a−b.
  - AND/OR/XOR and I-forms: bitwise.
  - SLL/SRL/SRA and I-forms: shift by shamt; SRA is arithmetic.
  - SLT/SLTI: signed compare, result 1/0.
  - SLTU/SLTIU: unsigned compare, result 1/0.
  - LUI: b.
  - Any other op: 0.
  - All arithmetic is 32-bit modulo; carries are discarded.
- Enqueue: when `req_valid && req_ready && !flush`, write the result and payload at the tail.
  - A request whose `epoch != cur_epoch` is handshaked (ready honoured) but not enqueued.
- Head classification:
  - Live: `uses_rd=1` and `epoch == cur_epoch`.
  - Dead: anything else.
- Dequeue:
  - Live head: dequeues on `wb_valid && wb_ready`.
  - Dead head: dequeues silently in one cycle with `wb_valid=0`. At most one dequeue per cycle.
- `req_ready = !rst && !flush && (count < DEPTH || (FULL_SKID && deq_fire))`.
- Flush: the next cycle has count=0 and pointers reset. In the flush cycle, `wb_valid=0` and no dequeue is reported.
- Same-cycle enqueue and dequeue: count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Latency: accepted at edge N → `wb_valid` high from cycle N+1 if the entry is at the head, live, and no flush.
- Throughput: 1 uop/cycle with `wb_ready` held high.
- `wb_valid` must not depend combinationally on `wb_ready`. Once `wb_valid` is asserted, the payload is stable until dequeue, unless `flush` fires or `cur_epoch` changes.
- Reset: in the cycle after `rst` is sampled high, all outputs read 0:
  - `wb_valid` 0, all `wb_*` payload 0, `occupancy` 0.
  - `req_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- Reset asserted mid-stream discards all entries; no `wb_valid` pulse follows.
- Empty queue: `wb_valid=0`. Full queue with `FULL_SKID=0`: `req_ready=0` even if the head dequeues.
- Epoch change while a live head is stalled: the head becomes dead and drains silently one entry per cycle.

## Structure
- `rs_uop_t`, `decoded_bundle_t`, `src_sel_e`, `alu_op_e`, `ROB_W`, `PHYS_W` stay in the shared defines package.
- Add a shared `alu_wb_entry_t` struct to that package: pc, uses_rd, rob_idx, prd_new, epoch, data.
- Sub-module `alu_core`: purely combinational operand mux plus result. The queue, pointers, and counter live in `alu_exec_q`.

## Test plan
- DEPTH=4, `wb_ready=1`, five back-to-back ADDI (x=5, imm=3) → `wb_valid` on cycles 1–5, data 8 each, `req_ready` stays 1.
- `wb_ready=0`, six requests:
  - FULL_SKID=0 → four accepted, `occupancy=4`, `req_ready=0`.
  - Raise `wb_ready` → in-order rob_idx 0–3 on consecutive cycles.
- Queue full, FULL_SKID=1, `wb_ready=1` plus a new request → accepted the same cycle, `occupancy` stays 4.
- Enqueue three entries (epoch 1), switch `cur_epoch` to 2 with `wb_ready=0` → all drain in 3 cycles with no `wb_valid`, `occupancy` reaches 0.
- `flush` with 3 entries and `req_valid=1` → `req_ready=0` and `wb_valid=0` that cycle; next cycle `occupancy=0`; request not enqueued.
- Arithmetic:
  - SRA 0x80000000 >>> 4 → 0xF8000000.
  - SLTU 1 < 0xFFFFFFFF → 1.
  - SLT 1 < 0xFFFFFFFF → 0.
  - `uses_rd=0` entry → silent dequeue.

Source files
------------

// File: rtl/alu_exec_q_pkg.sv
// Shared execute-stage definitions: the issued-uop format, operand-select and
// ALU-op encodings, and the writeback queue entry used by alu_exec_q.
package alu_exec_q_pkg;

  localparam int unsigned ROB_W  = 5;
  localparam int unsigned PHYS_W = 6;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RS1  = 2'd1,
    SRC_RS2  = 2'd2,
    SRC_IMM  = 2'd3
  } src_sel_e;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_ADDI  = 5'd1,
    ALU_AUIPC = 5'd2,
    ALU_SUB   = 5'd3,
    ALU_AND   = 5'd4,
    ALU_ANDI  = 5'd5,
    ALU_OR    = 5'd6,
    ALU_ORI   = 5'd7,
    ALU_XOR   = 5'd8,
    ALU_XORI  = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SLLI  = 5'd11,
    ALU_SRL   = 5'd12,
    ALU_SRLI  = 5'd13,
    ALU_SRA   = 5'd14,
    ALU_SRAI  = 5'd15,
    ALU_SLT   = 5'd16,
    ALU_SLTI  = 5'd17,
    ALU_SLTU  = 5'd18,
    ALU_SLTIU = 5'd19,
    ALU_LUI   = 5'd20
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     op;
    src_sel_e    src1_sel;
    src_sel_e    src2_sel;
    logic [31:0] imm;
    logic        uses_rd;
  } decoded_bundle_t;

  typedef struct packed {
    decoded_bundle_t   bundle;
    logic [ROB_W-1:0]  rob_idx;
    logic [PHYS_W-1:0] prd_new;
    logic [1:0]        epoch;
  } rs_uop_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic              uses_rd;
    logic [ROB_W-1:0]  rob_idx;
    logic [PHYS_W-1:0] prd_new;
    logic [1:0]        epoch;
    logic [31:0]       data;
  } alu_wb_entry_t;

endpackage

// File: rtl/alu_exec_q_core.sv
// alu_core: combinational RV32I integer ALU with operand selection.
//   op_i, src1_sel_i, src2_sel_i, imm_i : decoded uop fields
//   rs1_val_i, rs2_val_i               : register operands
//   result_o                           : 32-bit result (0 for unknown ops)
module alu_core
  import alu_exec_q_pkg::*;
(
  input  alu_op_e     op_i,
  input  src_sel_e    src1_sel_i,
  input  src_sel_e    src2_sel_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  output logic [31:0] result_o
);

  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;

  always_comb begin
    src1 = (src1_sel_i == SRC_RS1) ? rs1_val_i : '0;
    case (src2_sel_i)
      SRC_RS2: src2 = rs2_val_i;
      SRC_IMM: src2 = imm_i;
      default: src2 = '0;
    endcase
  end

  // Shift amount always comes from the immediate, for R- and I-forms alike.
  assign shamt = imm_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD, ALU_ADDI, ALU_AUIPC: result_o = src1 + src2;
      ALU_SUB:                      result_o = src1 - src2;
      ALU_AND, ALU_ANDI:            result_o = src1 & src2;
      ALU_OR, ALU_ORI:              result_o = src1 | src2;
      ALU_XOR, ALU_XORI:            result_o = src1 ^ src2;
      ALU_SLL, ALU_SLLI:            result_o = src1 << shamt;
      ALU_SRL, ALU_SRLI:            result_o = src1 >> shamt;
      ALU_SRA, ALU_SRAI:            result_o = $unsigned($signed(src1) >>> shamt);
      ALU_SLT, ALU_SLTI:            result_o = {31'd0, $signed(src1) < $signed(src2)};
      ALU_SLTU, ALU_SLTIU:          result_o = {31'd0, src1 < src2};
      ALU_LUI:                      result_o = src2;
      default:                      result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_q.sv
// alu_exec_q: RV32I execute unit. Results from alu_core are buffered in a
// DEPTH-entry in-order queue and offered to writeback via wb_valid/wb_ready.
// Entries from a stale epoch or without a destination drain silently.
//   clk, rst (sync, active high)
//   req_valid/req_ready/req_uop/rs1_val/rs2_val : issue port
//   cur_epoch : current front-end epoch; flush : drop everything this cycle
//   wb_valid/wb_ready/wb_* : head result to writeback
//   occupancy : number of valid entries
module alu_exec_q
  import alu_exec_q_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter bit          FULL_SKID = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  rs_uop_t                      req_uop,
  input  logic [31:0]                  rs1_val,
  input  logic [31:0]                  rs2_val,
  input  logic [1:0]                   cur_epoch,
  input  logic                         flush,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [31:0]                  wb_pc,
  output logic                         wb_uses_rd,
  output logic [ROB_W-1:0]             wb_rob_idx,
  output logic [PHYS_W-1:0]            wb_prd_new,
  output logic [1:0]                   wb_epoch,
  output logic [31:0]                  wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  alu_wb_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      alu_result;
  alu_wb_entry_t    new_ent;
  alu_wb_entry_t    head;
  logic             head_vld;
  logic             head_live;
  logic             deq_fire;
  logic             enq_fire;

  alu_core u_core (
    .op_i       (req_uop.bundle.op),
    .src1_sel_i (req_uop.bundle.src1_sel),
    .src2_sel_i (req_uop.bundle.src2_sel),
    .imm_i      (req_uop.bundle.imm),
    .rs1_val_i  (rs1_val),
    .rs2_val_i  (rs2_val),
    .result_o   (alu_result)
  );

  always_comb begin
    new_ent.pc      = req_uop.bundle.pc;
    new_ent.uses_rd = req_uop.bundle.uses_rd;
    new_ent.rob_idx = req_uop.rob_idx;
    new_ent.prd_new = req_uop.prd_new;
    new_ent.epoch   = req_uop.epoch;
    new_ent.data    = alu_result;
  end

  // Payload reads as zero whenever the queue is empty, so a freshly reset
  // block presents all-zero outputs without clearing the storage array.
  assign head_vld  = (count_q != '0);
  assign head      = head_vld ? mem_q[rd_ptr_q] : '0;
  assign head_live = head.uses_rd && (head.epoch == cur_epoch);

  assign wb_valid  = !rst && !flush && head_vld && head_live;
  // Dead heads leave without waiting for the consumer.
  assign deq_fire  = !rst && !flush && head_vld && (!head_live || wb_ready);
  assign req_ready = !rst && !flush && ((count_q < FULL_CNT) || (FULL_SKID && deq_fire));
  // Stale-epoch requests complete the handshake but are dropped here.
  assign enq_fire  = req_valid && req_ready && (req_uop.epoch == cur_epoch);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // With FULL_SKID a full queue writes the slot being read this same cycle;
  // the read is combinational so the outgoing head is unaffected.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= new_ent;
  end

  assign wb_pc      = head.pc;
  assign wb_uses_rd = head.uses_rd;
  assign wb_rob_idx = head.rob_idx;
  assign wb_prd_new = head.prd_new;
  assign wb_epoch   = head.epoch;
  assign wb_data    = head.data;
  assign occupancy  = count_q;

endmodule
